// File: rtl/rect_rasterizer.sv
// Clips a signed half-open rectangle to the screen and streams every covered
// pixel coordinate in raster order over a valid/ready interface.
module rect_rasterizer #(
  parameter int unsigned COORD_WIDTH   = 16,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic signed [COORD_WIDTH-1:0] rect_left_i,
  input  logic signed [COORD_WIDTH-1:0] rect_top_i,
  input  logic signed [COORD_WIDTH-1:0] rect_right_i,
  input  logic signed [COORD_WIDTH-1:0] rect_bottom_i,
  output logic                          busy_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic signed [COORD_WIDTH-1:0] out_x_o,
  output logic signed [COORD_WIDTH-1:0] out_y_o,
  output logic                          out_last_o,
  output logic                          done_o
);

  localparam int unsigned W = COORD_WIDTH;
  localparam int unsigned E = COORD_WIDTH + 1;

  localparam logic signed [E-1:0] ZERO_E = '0;
  localparam logic signed [E-1:0] ONE_E  = E'(1);
  localparam logic signed [E-1:0] SCR_W  = E'(SCREEN_WIDTH);
  localparam logic signed [E-1:0] SCR_H  = E'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {IDLE, CLIP, EMIT, DONE} state_e;

  state_e                state_q;
  logic signed [W-1:0]   left_q, top_q, right_q, bottom_q;
  logic signed [W-1:0]   cl_q;
  logic signed [E-1:0]   crm1_q, cbm1_q;
  logic                  busy_q, out_valid_q, out_last_q, done_q;
  logic signed [W-1:0]   out_x_q, out_y_q;

  logic signed [E-1:0]   left_e, top_e, right_e, bottom_e;
  logic signed [E-1:0]   cl_c, cr_c, ct_c, cb_c, crm1_c, cbm1_c;
  logic                  empty_c, first_last_c, row_end_c, next_last_c;
  logic signed [W-1:0]   nx_c, ny_c;

  function automatic logic signed [E-1:0] sx(input logic signed [W-1:0] v);
    return {v[W-1], v};
  endfunction

  // Clip bounds and raster stepping, all compared one bit wider so cr-1 / x+1 never wrap
  always_comb begin
    left_e       = sx(left_q);
    top_e        = sx(top_q);
    right_e      = sx(right_q);
    bottom_e     = sx(bottom_q);
    cl_c         = (left_e > ZERO_E) ? left_e : ZERO_E;
    ct_c         = (top_e > ZERO_E) ? top_e : ZERO_E;
    cr_c         = (right_e < SCR_W) ? right_e : SCR_W;
    cb_c         = (bottom_e < SCR_H) ? bottom_e : SCR_H;
    crm1_c       = cr_c - ONE_E;
    cbm1_c       = cb_c - ONE_E;
    empty_c      = (cl_c >= cr_c) || (ct_c >= cb_c);
    first_last_c = (cl_c == crm1_c) && (ct_c == cbm1_c);
    row_end_c    = (sx(out_x_q) >= crm1_q);
    nx_c         = row_end_c ? cl_q : out_x_q + W'(1);
    ny_c         = row_end_c ? out_y_q + W'(1) : out_y_q;
    next_last_c  = (sx(nx_c) == crm1_q) && (sx(ny_c) == cbm1_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      left_q      <= '0;
      top_q       <= '0;
      right_q     <= '0;
      bottom_q    <= '0;
      cl_q        <= '0;
      crm1_q      <= '0;
      cbm1_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            left_q   <= rect_left_i;
            top_q    <= rect_top_i;
            right_q  <= rect_right_i;
            bottom_q <= rect_bottom_i;
            busy_q   <= 1'b1;
            state_q  <= CLIP;
          end
        end
        CLIP: begin
          cl_q   <= W'(cl_c);
          crm1_q <= crm1_c;
          cbm1_q <= cbm1_c;
          if (empty_c) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            out_valid_q <= 1'b1;
            out_x_q     <= W'(cl_c);
            out_y_q     <= W'(ct_c);
            out_last_q  <= first_last_c;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          // Beat registers only move on a handshake, which keeps them stable under stall
          if (out_ready_i) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              out_x_q    <= nx_c;
              out_y_q    <= ny_c;
              out_last_q <= next_last_c;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign out_x_o     = out_x_q;
  assign out_y_o     = out_y_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;

endmodule

// File: doc/rect_rasterizer.md
# rect_rasterizer

Sequential point generator for the GPU: takes one rectangle, clips it to the screen and streams every pixel coordinate inside it in raster order over a valid/ready interface. It is the producer-side counterpart of the point-in-rect collision test. Every coordinate it emits satisfies left <= x < right and top <= y < bottom (signed, half-open). It feeds fill/clear engines and point-consuming stages that need an explicit pixel stream instead of per-pixel hit testing.

## Interface
- COORD_WIDTH, default `COORD_WIDTH (constants.svh): width of all signed coordinates.
- SCREEN_WIDTH, default 640: clip width; must be representable as positive signed COORD_WIDTH.
- SCREEN_HEIGHT, default 480: clip height; same constraint.

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- start  in  1  request; accepted only on a cycle with busy=0.
- rect_left, rect_top, rect_right, rect_bottom  in  COORD_WIDTH each  signed rectangle bounds, half-open; sampled only on the accepting cycle.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- out_valid  out  1  coordinate beat valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_x, out_y  out  COORD_WIDTH each  signed pixel coordinate.
- out_last  out  1  marks the final beat of the rectangle.
- done  out  1  one-cycle pulse when the rectangle is finished, including empty rectangles.

## Operation
- FSM states: IDLE, CLIP, EMIT, DONE.
- IDLE: busy=0. On start=1, register the rect inputs and go to CLIP. start while busy=1 is ignored and not queued.
- CLIP (1 cycle): compute clipped bounds and register them. All comparisons are signed.
  - cl = max(left, 0), cr = min(right, SCREEN_WIDTH).
  - ct = max(top, 0), cb = min(bottom, SCREEN_HEIGHT).
  - Empty if cl >= cr or ct >= cb; this covers zero width, inverted bounds and fully off-screen rects. Empty goes to DONE; otherwise load x=cl, y=ct and go to EMIT.
- EMIT: out_valid=1, out_x=x, out_y=y, out_last = (x == cr-1) && (y == cb-1). On handshake:
  - If x < cr-1: x++.
  - Else: x = cl, y++.
  - The handshake on the last beat goes to DONE.
- Stall rule: while out_valid && !out_ready, out_x, out_y and out_last are held stable. out_valid never drops before its handshake.
- DONE (1 cycle): done=1, busy=1, out_valid=0, then IDLE.
- Counters are COORD_WIDTH wide. Internal arithmetic (cr-1, x+1) is sign-extended by 1 bit, so comparisons at the clip bounds cannot wrap.
- Reset mid-operation abandons the rectangle. No done pulse and no further beats are produced.

## Timing
- Reset values: busy=0, out_valid=0, out_x=0, out_y=0, out_last=0, done=0, state IDLE.
- start accepted at edge t: CLIP during cycle t+1. The first out_valid (or the done pulse, if empty) appears in cycle t+2.
- Throughput: 1 beat/cycle with out_ready held at 1. Clipped area N pixels with no stalls: done in cycle t+2+N.
- done lasts exactly one cycle. The next start is accepted in the cycle after done, when busy=0.
- out_valid, out_x, out_y and out_last are registered outputs; none depends combinationally on out_ready.

## Test plan
- Rect (2,3,5,5), out_ready=1, start at cycle 0:
  - Beats (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) in cycles 2..7.
  - out_last only on (4,4); done in cycle 8; busy low in cycle 9.
- Same rect with out_ready pattern 1,0,0,1,0,1,1,1,...: the same 6 beats in order, each held unchanged while stalled; done the cycle after the 6th handshake.
- Clipping:
  - (-3,-2,2,1) gives exactly (0,0),(1,0), last on (1,0).
  - (630,470,700,500) gives 100 beats, x 630..639 by y 470..479; first (630,470), last (639,479).
- Empty rects (5,5,5,9), (10,0,4,4) and (-10,-10,-1,-1): no out_valid ever; done in cycle 2 after start.
- Single pixel (7,7,8,8): one beat (7,7) with out_last=1 in cycle 2, done in cycle 3.
- Control:
  - Pulse start with rect (0,0,1,1) during EMIT of rect (0,0,4,4): ignored, exactly 16 beats result.
  - Assert reset asynchronously mid-EMIT: all outputs are 0 before the next edge, no done pulse.
  - A new start after reset runs normally.
